// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared width constant, propagate/generate pair type and helper
//            for the 4-bit carry-lookahead adder.
// Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  typedef logic [CLA_WIDTH-1:0] nib_t;

  typedef struct packed {
    nib_t p;
    nib_t g;
  } pg_pair_t;

  // Bitwise propagate/generate terms for one operand pair.
  function automatic pg_pair_t pg_form(input nib_t a, input nib_t b);
    pg_pair_t r;
    r.p = a ^ b;
    r.g = a & b;
    return r;
  endfunction

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_4b_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b_if
// Purpose  : Operand/result bundle of the 4-bit CLA adder. The group
//            propagate/generate outputs exist only with CLA_4B_GROUP_PG_EN.
// Revision : 1.0  initial release
// ============================================================================
interface cla_4b_if;
  import cla_pkg::*;

  logic [CLA_WIDTH-1:0] A;
  logic [CLA_WIDTH-1:0] B;
  logic                 Cin;
  logic [CLA_WIDTH-1:0] S;
  logic                 Cout;
`ifdef CLA_4B_GROUP_PG_EN
  logic                 PG;
  logic                 GG;
`endif

`ifdef CLA_4B_GROUP_PG_EN
  modport master (output A, B, Cin, input  S, Cout, PG, GG);
  modport slave  (input  A, B, Cin, output S, Cout, PG, GG);
`else
  modport master (output A, B, Cin, input  S, Cout);
  modport slave  (input  A, B, Cin, output S, Cout);
`endif

endinterface : cla_4b_if
`default_nettype wire

// File: rtl/cla_4b_lcu.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b_lcu
// Purpose  : Combinational lookahead carry unit; every carry is a flat
//            sum-of-products of p/g/c0. Group PG/GG with CLA_4B_GROUP_PG_EN.
// Revision : 1.0  initial release
// ============================================================================
module cla_4b_lcu
  import cla_pkg::*;
(
  input  wire nib_t       p,
  input  wire nib_t       g,
  input  wire logic       c0,
`ifdef CLA_4B_GROUP_PG_EN
  output logic            PG,
  output logic            GG,
`endif
  output logic [4:1]      c
);

  // No carry term depends on another carry output: each is expanded fully.
  assign c[1] = g[0]
              | (p[0] & c0);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

`ifdef CLA_4B_GROUP_PG_EN
  assign PG = p[3] & p[2] & p[1] & p[0];

  assign GG = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
`endif

endmodule : cla_4b_lcu
`default_nettype wire

// File: rtl/cla_4b.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b
// Purpose  : 4-bit carry-lookahead adder, one-cycle registered {Cout,S}.
//            Optional group PG/GG outputs under CLA_4B_GROUP_PG_EN.
// Revision : 1.0  initial release
// ============================================================================
module cla_4b
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  wire logic clk,
  input  wire logic rst_n,
  cla_4b_if.slave   bus
);

  pg_pair_t          w_pg;
  logic [WIDTH:0]    w_c;
  logic [WIDTH-1:0]  w_sum;

  logic [WIDTH-1:0]  r_s;
  logic              r_cout;

  assign w_pg   = pg_form(bus.A, bus.B);
  assign w_c[0] = bus.Cin;

`ifdef CLA_4B_GROUP_PG_EN
  logic w_grp_p;
  logic w_grp_g;
  logic r_pg;
  logic r_gg;

  cla_4b_lcu u_lcu (
    .p  (w_pg.p),
    .g  (w_pg.g),
    .c0 (bus.Cin),
    .PG (w_grp_p),
    .GG (w_grp_g),
    .c  (w_c[4:1])
  );
`else
  cla_4b_lcu u_lcu (
    .p  (w_pg.p),
    .g  (w_pg.g),
    .c0 (bus.Cin),
    .c  (w_c[4:1])
  );
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_sum
    assign w_sum[i] = w_pg.p[i] ^ w_c[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_c[WIDTH];
    end
  end

  assign bus.S    = r_s;
  assign bus.Cout = r_cout;

`ifdef CLA_4B_GROUP_PG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pg <= 1'b0;
      r_gg <= 1'b0;
    end else begin
      r_pg <= w_grp_p;
      r_gg <= w_grp_g;
    end
  end

  assign bus.PG = r_pg;
  assign bus.GG = r_gg;
`endif

endmodule : cla_4b
`default_nettype wire

// File: tb/tb_cla_4b.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_4b
// Purpose  : Scoreboard bench for cla_4b (CLA_4B_GROUP_PG_EN adds PG/GG checks).
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_4b;

  typedef struct {
    string      tag;
    logic [4:0] sum;
    logic       pg;
    logic       gg;
  } exp_t;

  logic   clk;
  logic   rst_n;
  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  cla_4b_if bus_if ();

  cla_4b #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Drive one operand set, push its expected result, then compare one edge later.
  task automatic step(input logic rn, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input string tag);
    exp_t       e;
    logic [4:0] tot;
    logic [4:0] ab;
    rst_n     = rn;
    bus_if.A   = a;
    bus_if.B   = b;
    bus_if.Cin = ci;
    ab    = {1'b0, a} + {1'b0, b};
    tot   = ab + {4'b0000, ci};
    e.tag = tag;
    e.sum = rn ? tot : 5'd0;
    e.pg  = rn ? ((a ^ b) == 4'hF) : 1'b0;
    e.gg  = rn ? (ab > 5'd15) : 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_s"},    32'(bus_if.S),    32'(e.sum[3:0]));
    check({e.tag, "_cout"}, 32'(bus_if.Cout), 32'(e.sum[4]));
`ifdef CLA_4B_GROUP_PG_EN
    check({e.tag, "_pg"},   32'(bus_if.PG),   32'(e.pg));
    check({e.tag, "_gg"},   32'(bus_if.GG),   32'(e.gg));
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_if.A   = '0;
    bus_if.B   = '0;
    bus_if.Cin = 1'b0;

    step(1'b0, 4'd9, 4'd9, 1'b1, "rst0");
    step(1'b0, 4'd9, 4'd9, 1'b1, "rst1");

    step(1'b1, 4'd0, 4'd0, 1'b0, "b2b0");
    step(1'b1, 4'd3, 4'd5, 1'b0, "b2b1");
    step(1'b1, 4'd9, 4'd5, 1'b0, "b2b2");
    step(1'b1, 4'd6, 4'd7, 1'b1, "b2b3");

    step(1'b1, 4'd9,  4'd9,  1'b0, "ovf_9_9");
    step(1'b1, 4'd15, 4'd15, 1'b1, "ovf_15_15_1");
    step(1'b1, 4'd15, 4'd0,  1'b1, "ovf_15_0_1");

    step(1'b1, 4'd3, 4'd5, 1'b0, "mid_pre");
    step(1'b0, 4'd6, 4'd7, 1'b1, "mid_rst");
    step(1'b1, 4'd6, 4'd7, 1'b1, "mid_post");

    // A reset dip between edges must not disturb the registered outputs.
    rst_n = 1'b0;
    #3;
    check("async_rst_s",    32'(bus_if.S),    32'd14);
    check("async_rst_cout", 32'(bus_if.Cout), 32'd0);
    step(1'b1, 4'd1, 4'd2, 1'b0, "async_after");

    step(1'b1, 4'd5, 4'd10, 1'b0, "grp_5_10");
    step(1'b1, 4'd8, 4'd8,  1'b0, "grp_8_8");

    for (int i = 0; i < 512; i++)
      step(1'b1, i[3:0], i[7:4], i[8], "exh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cla_4b
`default_nettype wire
